// File: rtl/scan_pkg.sv
// Shared types and widths for the scan select sequencer.
// Holds the FSM state enumeration and the counter/select widths.
package scan_pkg;

  localparam int PRE_W = 16;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    PAUSE
  } state_e;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for the manual step request.
// pulse is high while d is high and was low on the previous edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  // Remember the previous-cycle level of d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/scan_select_sequencer.sv
// Scan select sequencer: prescaled or stepped select index for a decoder.
// Define SCAN_SELECT_BLANK_EN to blank en for one cycle on every advance.
module scan_select_sequencer
  import scan_pkg::*;
#(
  parameter int DIV  = 4,
  parameter int LAST = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic             wrap
);

  localparam logic [PRE_W-1:0] TOP_CNT  = PRE_W'(DIV - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(LAST);

  state_e           state_q, state_d;
  logic [PRE_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             en_q, en_d;
  logic             wrap_q, wrap_d;
  logic             step_rise;
  logic             tick;
  logic             manual;
  logic             advance;

  rise_detect u_step_rise (
    .clk   (clk),
    .rst   (rst),
    .d     (step),
    .pulse (step_rise)
  );

  // Next-state, prescaler and advance decisions for the sequencer.
  always_comb begin
    tick    = (state_q == SCAN) && run && (cnt_q == TOP_CNT);
    manual  = step_rise && !run && (state_q != SCAN);
    advance = tick || manual;

    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d = SCAN;
        end else if (step_rise) begin
          state_d = PAUSE;
        end
      end
      SCAN: begin
        if (!run) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (run) begin
          state_d = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase

    cnt_d = cnt_q;
    if ((state_q == SCAN) && run) begin
      cnt_d = tick ? '0 : cnt_q + PRE_W'(1);
    end

    sel_d  = sel_q;
    wrap_d = 1'b0;
    if (advance) begin
      if (sel_q == LAST_SEL) begin
        sel_d  = '0;
        wrap_d = 1'b1;
      end else begin
        sel_d = sel_q + SEL_W'(1);
      end
    end

`ifdef SCAN_SELECT_BLANK_EN
    en_d = (state_d != IDLE) && !advance;
`else
    en_d = (state_d != IDLE);
`endif
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      wrap_q  <= wrap_d;
    end
  end

  assign sel  = sel_q;
  assign en   = en_q;
  assign wrap = wrap_q;

endmodule
